// File: rtl/seqgen_pkg.sv
// ---------------------------------------------------------------------------
// seqgen_pkg
// Shared types and defaults for the serial sequence generator.
//   gen_state_t   : generator FSM state encoding (IDLE / SEND / DONE)
//   DEF_PATTERN_W : default maximum pattern length in bits
// ---------------------------------------------------------------------------
package seqgen_pkg;

    localparam int DEF_PATTERN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } gen_state_t;

endpackage

// File: rtl/sequence_generator_step_sync.sv
// ---------------------------------------------------------------------------
// step_sync
// Two-flop synchronizer followed by a registered rising-edge detector, for
// switch-style inputs that are asynchronous to clk.
//   clk       in  : system clock
//   reset_n   in  : asynchronous active-low reset
//   async_in  in  : raw asynchronous level
//   pulse_out out : one-cycle pulse, high after the 3rd clk edge following
//                   a rising edge on async_in
// ---------------------------------------------------------------------------
module step_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse_out
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= async_in;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            // Registered so the pulse carries no combinational path to users.
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign pulse_out = r_pulse;

endmodule

// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
// Serial bit-pattern transmitter. Loads a pattern of 1..PATTERN_W bits and
// shifts it out MSB-first, one bit per synchronized step_raw rising edge.
//   clk        in  : 50 MHz system clock
//   reset_n    in  : asynchronous active-low reset
//   step_raw   in  : raw step switch; each rising edge advances one bit
//   start      in  : load pattern/length and begin (IDLE only)
//   abort      in  : cancel a transmission in SEND, no done pulse
//   repeat_en  in  : restart the pattern after its last bit
//   pattern    in  : bits to send, pattern[length-1] first
//   length     in  : number of bits (0 ignored, >PATTERN_W clamped)
//   data_out   out : current serial bit
//   busy       out : high while in SEND
//   done       out : one-cycle pulse after a non-repeating run completes
//   bit_idx    out : bits remaining including the current one, 0 when idle
// ---------------------------------------------------------------------------
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int PATTERN_W = DEF_PATTERN_W,
    parameter int CNT_W     = $clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step_raw,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 repeat_en,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [CNT_W-1:0]     length,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     bit_idx
);

    gen_state_t             r_state;
    gen_state_t             w_state_nxt;
    logic [PATTERN_W-1:0]   r_shreg;
    logic [PATTERN_W-1:0]   r_pat;
    logic [CNT_W-1:0]       r_len;
    logic [CNT_W-1:0]       r_idx;

    logic                   w_step_p;
    logic [CNT_W-1:0]       w_len_clamp;
    logic                   w_start_go;
    logic                   w_last_bit;
    logic                   w_busy;
    logic                   w_done;

    // Left-justify the active bits so the first bit to send sits at the MSB.
    function automatic logic [PATTERN_W-1:0] align_pat(
        input logic [PATTERN_W-1:0] p,
        input logic [CNT_W-1:0]     n
    );
        return p << (CNT_W'(PATTERN_W) - n);
    endfunction

    step_sync u_step_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .async_in  (step_raw),
        .pulse_out (w_step_p)
    );

    assign w_len_clamp = (length > CNT_W'(PATTERN_W)) ? CNT_W'(PATTERN_W) : length;
    assign w_start_go  = (r_state == IDLE) && start && (length != '0);
    assign w_last_bit  = (r_idx == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; abort outranks a coincident step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start_go) w_state_nxt = SEND;
            SEND: begin
                if (abort)                                     w_state_nxt = IDLE;
                else if (w_step_p && w_last_bit && !repeat_en) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decodes of registered state only.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            SEND:    w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Shift register and bit counter. Both are cleared whenever SEND is left
    // so data_out and bit_idx read 0 outside a transmission.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        r_pat   <= pattern;
                        r_len   <= w_len_clamp;
                        r_shreg <= align_pat(pattern, w_len_clamp);
                        r_idx   <= w_len_clamp;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_shreg <= '0;
                        r_idx   <= '0;
                    end else if (w_step_p) begin
                        if (!w_last_bit) begin
                            r_shreg <= r_shreg << 1;
                            r_idx   <= r_idx - CNT_W'(1);
                        end else if (repeat_en) begin
                            r_shreg <= align_pat(r_pat, r_len);
                            r_idx   <= r_len;
                        end else begin
                            r_shreg <= '0;
                            r_idx   <= '0;
                        end
                    end
                end
                default: begin
                    r_shreg <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign data_out = r_shreg[PATTERN_W-1];
    assign bit_idx  = r_idx;
    assign busy     = w_busy;
    assign done     = w_done;

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
// Self-checking bench for sequence_generator. A transaction-level model holds
// the loaded pattern and the count of remaining bits; the expected serial bit
// is simply pattern[remaining-1].
// ---------------------------------------------------------------------------
module tb_sequence_generator;

    localparam int PW = 8;
    localparam int CW = $clog2(PW + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          step_raw = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          repeat_en = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [CW-1:0] length = '0;
    logic          data_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_idx;

    int checks = 0;
    int errors = 0;

    // reference model
    bit        m_busy = 1'b0;
    bit [7:0]  m_pat  = '0;
    int        m_len  = 0;
    int        m_rem  = 0;
    int        m_done = 0;
    int        done_seen = 0;

    sequence_generator #(.PATTERN_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .step_raw  (step_raw),
        .start     (start),
        .abort     (abort),
        .repeat_en (repeat_en),
        .pattern   (pattern),
        .length    (length),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (reset_n && done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_bit();
        return m_busy ? m_pat[m_rem-1] : 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "/dout"}, 32'(data_out), 32'(exp_bit()));
        chk({tag, "/busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "/idx"},  32'(bit_idx), 32'(m_rem));
        chk({tag, "/done"}, 32'(done_seen), 32'(m_done));
    endtask

    task automatic do_start(input logic [7:0] p, input logic [3:0] l);
        @(negedge clk);
        pattern = p;
        length  = l;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_busy && l != 0) begin
            m_busy = 1'b1;
            m_pat  = p;
            m_len  = (l > PW) ? PW : int'(l);
            m_rem  = m_len;
        end
    endtask

    task automatic do_step(input bit rep, input string tag);
        @(negedge clk);
        repeat_en = rep;
        pattern   = 8'($urandom);
        length    = 4'($urandom);
        step_raw  = 1'b1;
        repeat (6) @(negedge clk);
        step_raw = 1'b0;
        repeat (4) @(negedge clk);
        if (m_busy) begin
            if (m_rem > 1)  m_rem--;
            else if (rep)   m_rem = m_len;
            else begin
                m_busy = 1'b0;
                m_rem  = 0;
                m_done++;
            end
        end
        check_outputs(tag);
    endtask

    task automatic do_abort(input string tag);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_busy = 1'b0;
        m_rem  = 0;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("post_reset");

        // basic 8-bit run
        do_start(8'b1011_0010, 4'd8);
        check_outputs("basic_load");
        for (int i = 0; i < 8; i++) do_step(1'b0, "basic");
        repeat (3) @(negedge clk);
        check_outputs("basic_idle");

        // short pattern, upper bits don't care
        do_start(8'b1010_0110, 4'd4);
        check_outputs("short_load");
        for (int i = 0; i < 4; i++) do_step(1'b0, "short");

        // repeat mode, then drop repeat_en
        do_start(8'b0000_0101, 4'd3);
        for (int i = 0; i < 7; i++) do_step(1'b1, "repeat");
        for (int i = 0; i < 4 && m_busy; i++) do_step(1'b0, "repeat_end");

        // rejected start, ignored restart
        do_start(8'hFF, 4'd0);
        check_outputs("len0");
        do_start(8'b1011_0010, 4'd8);
        do_step(1'b0, "restart");
        do_step(1'b0, "restart");
        do_start(8'h0F, 4'd5);
        check_outputs("restart_ign");
        while (m_busy) do_step(1'b0, "restart_run");

        // length clamp
        do_start(8'b1100_1010, 4'd13);
        check_outputs("clamp_load");
        while (m_busy) do_step(1'b0, "clamp");

        // abort coincident with the step pulse after 3 bits
        do_start(8'b1011_0010, 4'd8);
        for (int i = 0; i < 3; i++) do_step(1'b0, "abort_pre");
        @(negedge clk);
        step_raw = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_busy = 1'b0;
        m_rem  = 0;
        check_outputs("abort_step");
        step_raw = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs("abort_after");

        // asynchronous reset mid-run
        do_start(8'b1110_0111, 4'd8);
        do_step(1'b0, "rst_pre");
        do_step(1'b0, "rst_pre");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        m_busy = 1'b0;
        m_rem  = 0;
        check_outputs("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("rst_after");

        // synchronizer latency: first changed bit 4 edges after the rise
        do_start(8'b1010_1010, 4'd8);
        @(negedge clk);
        step_raw = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sync_e%0d", e), 32'(data_out), (e < 4) ? 32'd1 : 32'd0);
        end
        repeat (6) @(negedge clk);
        step_raw = 1'b0;
        repeat (4) @(negedge clk);
        m_rem--;
        check_outputs("sync_one");
        do_abort("sync_clean");

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            do_start(8'($urandom), 4'($urandom_range(0, 12)));
            check_outputs("rnd_load");
            for (int s = 0; s < 12; s++) begin
                case ($urandom_range(0, 9))
                    0: do_abort("rnd_abort");
                    1: begin
                        do_start(8'($urandom), 4'($urandom_range(0, 12)));
                        check_outputs("rnd_start");
                    end
                    default: do_step($urandom_range(0, 3) == 0, "rnd_step");
                endcase
            end
            if (m_busy) do_abort("rnd_clean");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
